// File: rtl/uart_pkg.sv
// uart_pkg: frame states, line levels and width helper shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam logic UART_IDLE = 1'b1;
  localparam logic UART_START = 1'b0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/uart_baud_div.sv
// uart_baud_div: free-running CLK_PER_BIT divider with sync clear and one-cycle terminal-count pulse.
module uart_baud_div
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = clog2(CLK_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLK_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: one byte per valid/ready handshake onto RsTx; start, data, optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 8,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 RsTx
);
  localparam int BW = clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || LSB_FIRST < 0 || LSB_FIRST > 1 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_transmitter: parameter out of range");
  end
  uart_state_t state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic acc, tick, last_data, last_stop, bit_nxt, par_bit, line_nxt;
  assign tx_ready  = state == IDLE;
  assign tx_busy   = ~tx_ready;
  assign acc       = tx_valid && tx_ready;
  assign last_data = bit_cnt == LAST_DATA;
  assign last_stop = bit_cnt == LAST_STOP;
  uart_baud_div #(.CLK_PER_BIT(CLK_PER_BIT)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc),
    .tick (tick)
  );
`ifdef UART_TX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
  logic par;
  // Parity is taken from the byte at accept, since the shift register is consumed as bits go out.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else if (acc) par <= (^tx_data) ^ (PARITY_ODD != 0);
  assign par_bit = par;
`else
  localparam uart_state_t AFTER_DATA = STOP;
  assign par_bit = UART_IDLE;
`endif
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sh_nxt      = sh;
    case (state)
      IDLE:
        if (acc) begin
          state_nxt = START;
          sh_nxt    = tx_data;
        end
      START: if (tick) state_nxt = DATA;
      DATA:
        if (tick) begin
          sh_nxt      = (LSB_FIRST != 0) ? sh >> 1 : sh << 1;
          bit_cnt_nxt = last_data ? '0 : bit_cnt + 1'b1;
          state_nxt   = last_data ? AFTER_DATA : DATA;
        end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP:
        if (tick) begin
          bit_cnt_nxt = last_stop ? '0 : bit_cnt + 1'b1;
          state_nxt   = last_stop ? IDLE : STOP;
        end
      default: state_nxt = IDLE;
    endcase
    bit_nxt  = (LSB_FIRST != 0) ? sh_nxt[0] : sh_nxt[DATA_BITS-1];
    line_nxt = state_nxt == START  ? UART_START :
               state_nxt == DATA   ? bit_nxt :
               state_nxt == PARITY ? par_bit : UART_IDLE;
  end
  // RsTx registers the level of the next state so it changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      RsTx    <= UART_IDLE;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sh      <= sh_nxt;
      RsTx    <= line_nxt;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame vectors plus back-to-back and mid-frame reset sequences.
module tb_uart_transmitter;
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic rdy_m, bsy_m, rs_m, rdy_l, bsy_l, rs_l;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_transmitter #(.CLK_PER_BIT(8), .LSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_m), .tx_busy(bsy_m), .RsTx(rs_m)
  );
  uart_transmitter #(.CLK_PER_BIT(8), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_l), .tx_busy(bsy_l), .RsTx(rs_l)
  );
`ifdef UART_TX_PARITY_EN
  logic rdy_e, bsy_e, rs_e, rdy_o, bsy_o, rs_o;
  uart_transmitter #(.CLK_PER_BIT(8), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_e), .tx_busy(bsy_e), .RsTx(rs_e)
  );
  uart_transmitter #(.CLK_PER_BIT(8), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_o), .tx_busy(bsy_o), .RsTx(rs_o)
  );
`endif
  typedef struct {
    logic [7:0] data;
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       par;
  } vec_t;
  vec_t vecs[6];
  function automatic logic exp_line(input logic [7:0] seq, input logic par, input bit has_par,
                                    input int k);
    int b;
    b = k / 8;
    if (b == 0) return 1'b0;
    if (b <= 8) return seq[8-b];
    if (has_par && b == 9) return par;
    return 1'b1;
  endfunction
  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic frame(input vec_t v);
    logic lm[96], ll[96];
    int bm, bl;
`ifdef UART_TX_PARITY_EN
    logic le[96], lo[96];
    int be, bo;
    be = 0;
    bo = 0;
`endif
    bm = 0;
    bl = 0;
    @(negedge clk);
    tx_data  = v.data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 96; k++) begin
      lm[k] = rs_m;
      ll[k] = rs_l;
      bm += rdy_m ? 0 : 1;
      bl += rdy_l ? 0 : 1;
`ifdef UART_TX_PARITY_EN
      le[k] = rs_e;
      lo[k] = rs_o;
      be += rdy_e ? 0 : 1;
      bo += rdy_o ? 0 : 1;
`endif
      @(negedge clk);
    end
    for (int k = 0; k < 96; k++) begin
      check($sformatf("msb %h cyc %0d", v.data, k), lm[k], exp_line(v.msb, 1'b0, 1'b0, k));
      check($sformatf("lsb %h cyc %0d", v.data, k), ll[k], exp_line(v.lsb, 1'b0, 1'b0, k));
`ifdef UART_TX_PARITY_EN
      check($sformatf("even %h cyc %0d", v.data, k), le[k], exp_line(v.msb, v.par, 1'b1, k));
      check($sformatf("odd %h cyc %0d", v.data, k), lo[k], exp_line(v.msb, ~v.par, 1'b1, k));
`endif
    end
    check_int($sformatf("busy msb %h", v.data), bm, 80);
    check_int($sformatf("busy lsb %h", v.data), bl, 80);
`ifdef UART_TX_PARITY_EN
    check_int($sformatf("busy even %h", v.data), be, 88);
    check_int($sformatf("busy odd %h", v.data), bo, 88);
`endif
  endtask
  initial begin
    logic lb[171], rb[171];
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
    vecs[2] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    vecs[3] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
    vecs[4] = '{8'h81, 8'h81, 8'h81, 1'b0};
    vecs[5] = '{8'hC4, 8'hC4, 8'h23, 1'b1};
    repeat (3) @(negedge clk);
    check("reset RsTx", rs_m, 1'b1);
    check("reset ready", rdy_m, 1'b1);
    check("reset busy", bsy_m, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check($sformatf("idle RsTx cyc %0d", k), rs_m, 1'b1);
      check($sformatf("idle ready cyc %0d", k), rdy_m, 1'b1);
    end
    for (int i = 0; i < 6; i++) frame(vecs[i]);
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 171; k++) begin
      lb[k] = rs_m;
      rb[k] = rdy_m;
      check($sformatf("b2b busy cyc %0d", k), bsy_m, ~rdy_m);
      if (k == 10) tx_data = 8'hFF;
      if (k == 81) tx_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 171; k++) begin
      check($sformatf("b2b RsTx cyc %0d", k), lb[k],
            k < 81 ? exp_line(8'h00, 1'b0, 1'b0, k) : exp_line(8'hFF, 1'b0, 1'b0, k - 81));
      check($sformatf("b2b ready cyc %0d", k), rb[k], logic'(k == 80 || k > 160));
    end
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("midframe busy before reset", rdy_m, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midframe reset RsTx", rs_m, 1'b1);
    check("midframe reset ready", rdy_m, 1'b1);
    check("midframe reset RsTx lsb", rs_l, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset ready", rdy_m, 1'b1);
    check("after reset RsTx", rs_m, 1'b1);
    frame(vecs[4]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one byte per handshake onto the board UART TX pin (RsTx), idle-high, 1 start bit, DATA_BITS data bits, STOP_BITS stop bits.
- Companion to the team's UART receiver. Sits between the user-side byte source (FIFO/controller) and the pin.
- Bit timing comes from an internal clk divider. No external baud tick.

Parameters:
- CLK_PER_BIT, 8: clk cycles per serial bit. Legal range 2..65535.
- DATA_BITS, 8: payload bits per frame. Legal range 5..8.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- LSB_FIRST, 0: 0 sends MSB first, matching the team's receiver shift order. 1 sends LSB first (standard UART).
- PARITY_ODD, 0: selects odd parity when the parity feature is compiled in. 0 = even.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  DATA_BITS  byte to send; sampled only on accept
- tx_valid  in  1  source has a byte
- tx_ready  out  1  block can accept a byte this cycle
- tx_busy  out  1  frame in progress; equals ~tx_ready
- RsTx  out  1  serial line, registered, idle 1

Behaviour:
- Reset (async assert, sync release): RsTx=1, tx_ready=1, tx_busy=0, state=IDLE, bit counter=0, divider=0, shift register=0.
- Accept: occurs on a rising edge where tx_valid && tx_ready. tx_data is latched into the shift register. tx_ready is asserted only in IDLE, and its value does not depend on tx_valid. tx_valid while busy is ignored; no data loss, the source holds.
- Latency: on accept at edge N, RsTx=0 (start bit) from edge N+1.
- States:
  - IDLE: RsTx=1. On accept, go to START.
  - START: RsTx=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: RsTx=current bit for CLK_PER_BIT cycles. Shift after each bit. After DATA_BITS bits, go to PARITY if compiled in, else STOP.
  - PARITY: RsTx=parity bit for CLK_PER_BIT cycles, then go to STOP.
  - STOP: RsTx=1 for STOP_BITS*CLK_PER_BIT cycles, then go to IDLE.
- Divider: counts 0..CLK_PER_BIT-1 and wraps. Its terminal count advances the bit. It is cleared on accept so every bit is exactly CLK_PER_BIT cycles.
- Bit counter: width = clog2(DATA_BITS+1). Wraps to 0 on leaving DATA.
- Frame length: (1+DATA_BITS+STOP_BITS[+1 parity])*CLK_PER_BIT cycles of busy.
- tx_ready is low from edge N+1 until the edge ending the last stop cycle. Returns high in IDLE, so the earliest next accept is the first IDLE cycle. Back-to-back frames therefore have no extra idle bit beyond the stop bits.
- RsTx is driven straight from a flop. No combinational path from inputs to RsTx.
- Reset mid-frame: RsTx goes to 1 immediately (async), the frame is dropped, tx_ready=1 after release.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted after the data bits. Parity bit = XOR of the latched data bits, inverted when PARITY_ODD=1. The frame grows by one bit.
- Undefined: no PARITY state, no parity logic, and PARITY_ODD has no effect.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, START, DATA, PARITY, STOP}, shared with the receiver;
  - the line levels UART_IDLE=1 and UART_START=0;
  - a clog2 helper.
- One natural sub-module: uart_baud_div. It is a CLK_PER_BIT counter with a sync clear input and a one-cycle terminal-count pulse output, and it is reusable by the receiver.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then release. Required: RsTx=1, tx_ready=1 throughout, no transitions for 100 cycles.
- Single frame (CLK_PER_BIT=8, MSB first): tx_data=0xA5 pulsed valid 1 cycle. Required: RsTx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 8 cycles; tx_ready low for 80 cycles.
- LSB_FIRST=1 with 0x01: required first data bit 1, then seven 0s.
- Back-to-back: 0x00 then 0xFF with tx_valid held high. Required: the second accept occurs on the first cycle tx_ready=1, and the start bit follows the 8-cycle stop with no gap. tx_data changes while busy are ignored; the frame still sends 0x00.
- Reset mid-frame: assert rst_n at cycle 30 of 0x3C. Required: RsTx=1 the same cycle; after release, tx_ready=1 and the next frame 0x81 is sent intact.
- UART_TX_PARITY_EN, PARITY_ODD=0: 0xA5 gives parity 0 and 0x07 gives parity 1, 88-cycle frame. With PARITY_ODD=1, both values invert.
